sm83_ir_queue: RTL and testbench

//  Instruction-register front end for the SM83 core. It sits between the bus fetch path and the

---
 rtl/sm83_pkg.sv | 34 +++
 rtl/sm83_ir_queue_if.sv | 33 +++
 rtl/sm83_ir_class.sv | 96 +++++++++
 rtl/sm83_ir_queue.sv | 196 +++++++++++++++++++
 tb/tb_sm83_ir_queue.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sm83_pkg.sv
// Shared types and constants for the SM83 instruction-register front end:
// opcode class encoding, special opcodes and the queue FSM state type.
package sm83_pkg;

  localparam int SM83_WORD_SIZE   = 8;
  localparam int SM83_QUEUE_DEPTH = 2;

  // Coarse opcode class handed to the sequencer alongside ir.
  typedef enum logic [2:0] {
    CLS_NOP  = 3'd0,
    CLS_ALU  = 3'd1,
    CLS_LD8  = 3'd2,
    CLS_LD16 = 3'd3,
    CLS_JUMP = 3'd4,
    CLS_CB   = 3'd5,
    CLS_MISC = 3'd6
  } sm83_opc_class_t;

  localparam logic [7:0] OPC_PREFIX_CB = 8'hCB;
  localparam logic [7:0] OPC_HALT      = 8'h76;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_PREFIX = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_HALT   = 2'd3
  } ir_state_t;

  // HALT only exists in the unprefixed bank; CB 0x76 is BIT 6,(HL).
  function automatic logic is_halt_opcode(input logic cb, input logic [7:0] opcode);
    return !cb && (opcode == OPC_HALT);
  endfunction

endpackage

// File: rtl/sm83_ir_queue_if.sv
// Bundle of the fetch-side and issue-side signals of the instruction queue.
// slave is the queue itself, master is the fetch unit / sequencer side.
interface sm83_ir_queue_if #(
  parameter int WORD_SIZE = 8
) ();
  import sm83_pkg::*;

  logic                 fetch_valid;
  logic [WORD_SIZE-1:0] fetch_data;
  logic                 fetch_ready;
  logic                 flush;
  logic                 issue_valid;
  logic                 issue_ready;
  logic [WORD_SIZE-1:0] ir;
  logic                 bank_cb;
  sm83_opc_class_t      op_class;
  logic [1:0]           imm_len;
  logic                 irq_pending;
  logic                 ime;
  logic                 in_halt;
  logic                 halt_bug;

  modport master (
    output fetch_valid, fetch_data, flush, issue_ready, irq_pending, ime,
    input  fetch_ready, issue_valid, ir, bank_cb, op_class, imm_len, in_halt, halt_bug
  );

  modport slave (
    input  fetch_valid, fetch_data, flush, issue_ready, irq_pending, ime,
    output fetch_ready, issue_valid, ir, bank_cb, op_class, imm_len, in_halt, halt_bug
  );

endinterface

// File: rtl/sm83_ir_class.sv
// Combinational opcode classifier: maps {bank_cb, opcode} to a coarse class
// and the number of immediate bytes that follow the opcode in the stream.
// Decoding uses the usual x/y/z split of the opcode (x=[7:6], y=[5:3], z=[2:0]).
module sm83_ir_class
  import sm83_pkg::*;
(
  input  logic            bank_cb,
  input  logic [7:0]      opcode,
  output sm83_opc_class_t op_class,
  output logic [1:0]      imm_len
);

  logic [1:0] x;
  logic [2:0] y;
  logic [2:0] z;

  assign x = opcode[7:6];
  assign y = opcode[5:3];
  assign z = opcode[2:0];

  // Class decode; CB bank is uniform, unprefixed bank splits by quadrant.
  always_comb begin
    op_class = CLS_MISC;
    if (bank_cb) begin
      op_class = CLS_CB;
    end else if (opcode == 8'h00) begin
      op_class = CLS_NOP;
    end else if (opcode == OPC_HALT) begin
      op_class = CLS_MISC;
    end else begin
      case (x)
        2'b01: op_class = CLS_LD8;
        2'b10: op_class = CLS_ALU;
        2'b00: begin
          case (z)
            3'd0: begin
              if (y == 3'd1)      op_class = CLS_LD16;  // LD (nn),SP
              else if (y == 3'd2) op_class = CLS_MISC;  // STOP
              else                op_class = CLS_JUMP;  // JR family
            end
            3'd1:    op_class = y[0] ? CLS_ALU : CLS_LD16;  // ADD HL,rr / LD rr,nn
            3'd2,
            3'd6:    op_class = CLS_LD8;
            default: op_class = CLS_ALU;                   // INC/DEC, rotates, DAA...
          endcase
        end
        default: begin
          case (z)
            3'd0: begin
              if (y < 3'd4)                      op_class = CLS_JUMP;  // RET cc
              else if (y == 3'd5)                op_class = CLS_ALU;   // ADD SP,e
              else if (y == 3'd7)                op_class = CLS_LD16;  // LD HL,SP+e
              else                               op_class = CLS_LD8;   // LDH
            end
            3'd1: begin
              if (!y[0] || y == 3'd7)            op_class = CLS_LD16;  // POP, LD SP,HL
              else                               op_class = CLS_JUMP;  // RET, RETI, JP HL
            end
            3'd2:    op_class = (y < 3'd4) ? CLS_JUMP : CLS_LD8;
            3'd3:    op_class = (y == 3'd0) ? CLS_JUMP : CLS_MISC;
            3'd4:    op_class = (y < 3'd4) ? CLS_JUMP : CLS_MISC;
            3'd5: begin
              if (!y[0])                         op_class = CLS_LD16;  // PUSH
              else if (y == 3'd1)                op_class = CLS_JUMP;  // CALL nn
              else                               op_class = CLS_MISC;
            end
            3'd6:    op_class = CLS_ALU;
            default: op_class = CLS_JUMP;                              // RST
          endcase
        end
      endcase
    end
  end

  // Immediate length decode; CB-bank opcodes never carry immediates.
  always_comb begin
    imm_len = 2'd0;
    if (!bank_cb) begin
      if (x == 2'b00) begin
        if (z == 3'd1 && !y[0])               imm_len = 2'd2;  // LD rr,nn
        else if (z == 3'd0 && y == 3'd1)      imm_len = 2'd2;  // LD (nn),SP
        else if (z == 3'd6)                   imm_len = 2'd1;  // LD r,n
        else if (z == 3'd0 && y >= 3'd2)      imm_len = 2'd1;  // STOP, JR
      end else if (x == 2'b11) begin
        if (z == 3'd6)                        imm_len = 2'd1;  // ALU A,n
        else if (z == 3'd0 && y >= 3'd4)      imm_len = 2'd1;  // LDH, ADD SP / LD HL,SP+e
        else if (z == 3'd2 && (y < 3'd4 || y == 3'd5 || y == 3'd7))
                                              imm_len = 2'd2;  // JP cc, LD (nn),A / A,(nn)
        else if (z == 3'd3 && y == 3'd0)      imm_len = 2'd2;  // JP nn
        else if (z == 3'd4 && y < 3'd4)       imm_len = 2'd2;  // CALL cc
        else if (z == 3'd5 && y == 3'd1)      imm_len = 2'd2;  // CALL nn
      end
    end
  end

endmodule

// File: rtl/sm83_ir_queue.sv
// Instruction-register front end: a small prefetch FIFO feeding a
// FETCH/PREFIX/ISSUE/HALT state machine that folds the CB prefix, classifies
// the opcode and presents it on a valid/ready handshake. Also owns HALT and
// the HALT-bug replay, where the byte after HALT is read without being popped.
module sm83_ir_queue
  import sm83_pkg::*;
#(
  parameter int WORD_SIZE   = SM83_WORD_SIZE,
  parameter int QUEUE_DEPTH = SM83_QUEUE_DEPTH
) (
  input  logic           clk,
  input  logic           nreset,
  sm83_ir_queue_if.slave bus
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // FIFO storage and bookkeeping
  logic [WORD_SIZE-1:0] mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 replay_q, replay_d;

  // FSM and registered issue outputs
  ir_state_t            state_q, state_d;
  logic [WORD_SIZE-1:0] ir_q, ir_d;
  logic                 bank_cb_q, bank_cb_d;
  sm83_opc_class_t      op_class_q, op_class_d;
  logic [1:0]           imm_len_q, imm_len_d;
  logic                 halt_bug_q, halt_bug_d;

  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 pop_advance;
  logic [WORD_SIZE-1:0] head_byte;
  sm83_opc_class_t      head_class;
  logic [1:0]           head_imm_len;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(QUEUE_DEPTH));
  assign head_byte  = mem_q[rd_ptr_q];

  // The classifier sees the head byte in the bank it will be issued from.
  sm83_ir_class u_class (
    .bank_cb  (state_q == ST_PREFIX),
    .opcode   (head_byte[7:0]),
    .op_class (head_class),
    .imm_len  (head_imm_len)
  );

  // Next-state, FIFO pointer and issue-register logic.
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    replay_d    = replay_q;
    ir_d        = ir_q;
    bank_cb_d   = bank_cb_q;
    op_class_d  = op_class_q;
    imm_len_d   = imm_len_q;
    halt_bug_d  = 1'b0;
    fifo_push   = bus.fetch_valid && !fifo_full;
    fifo_pop    = 1'b0;
    pop_advance = 1'b0;

    if (bus.flush) begin
      state_d   = ST_FETCH;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      replay_d  = 1'b0;
      bank_cb_d = 1'b0;
      fifo_push = 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            if (head_byte == WORD_SIZE'(OPC_PREFIX_CB)) begin
              state_d   = ST_PREFIX;
              bank_cb_d = 1'b1;
            end else begin
              state_d    = ST_ISSUE;
              ir_d       = head_byte;
              bank_cb_d  = 1'b0;
              op_class_d = head_class;
              imm_len_d  = head_imm_len;
            end
          end
        end
        ST_PREFIX: begin
          // Any byte after the prefix, including 0xCB, is a CB-bank opcode.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            state_d    = ST_ISSUE;
            ir_d       = head_byte;
            op_class_d = head_class;
            imm_len_d  = head_imm_len;
          end
        end
        ST_ISSUE: begin
          if (bus.issue_ready) begin
            if (is_halt_opcode(bank_cb_q, ir_q[7:0])) begin
              if (bus.irq_pending && !bus.ime) begin
                state_d    = ST_FETCH;
                replay_d   = 1'b1;
                halt_bug_d = 1'b1;
              end else if (bus.irq_pending) begin
                state_d = ST_FETCH;
              end else begin
                state_d = ST_HALT;
              end
            end else begin
              state_d = ST_FETCH;
            end
          end
        end
        ST_HALT: begin
          if (bus.irq_pending) begin
            state_d = ST_FETCH;
          end
        end
        default: state_d = ST_FETCH;
      endcase

      // A replayed pop reads the head but leaves it in the FIFO.
      if (fifo_pop) begin
        if (replay_q) begin
          replay_d = 1'b0;
        end else begin
          pop_advance = 1'b1;
          rd_ptr_d    = rd_ptr_q + PTR_W'(1);
        end
      end

      if (fifo_push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end

      case ({fifo_push, pop_advance})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control and issue registers, cleared immediately on reset assertion.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_FETCH;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      replay_q   <= 1'b0;
      ir_q       <= '0;
      bank_cb_q  <= 1'b0;
      op_class_q <= CLS_NOP;
      imm_len_q  <= 2'd0;
      halt_bug_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      replay_q   <= replay_d;
      ir_q       <= ir_d;
      bank_cb_q  <= bank_cb_d;
      op_class_q <= op_class_d;
      imm_len_q  <= imm_len_d;
      halt_bug_q <= halt_bug_d;
    end
  end

  // FIFO payload; entries are only read while the count says they are valid.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      mem_q[wr_ptr_q] <= bus.fetch_data;
    end
  end

  assign bus.fetch_ready = !fifo_full;
  assign bus.issue_valid = (state_q == ST_ISSUE);
  assign bus.in_halt     = (state_q == ST_HALT);
  assign bus.ir          = ir_q;
  assign bus.bank_cb     = bank_cb_q;
  assign bus.op_class    = op_class_q;
  assign bus.imm_len     = imm_len_q;
  assign bus.halt_bug    = halt_bug_q;

endmodule

// File: tb/tb_sm83_ir_queue.sv
// Bench for sm83_ir_queue: directed scenarios for latency, CB folding, HALT,
// HALT bug, flush and reset, followed by a random byte stream checked against
// an instruction-level reference model (prefix folding + opcode tables).
module tb_sm83_ir_queue;
  import sm83_pkg::*;

  logic clk = 1'b0;
  logic nreset = 1'b1;
  always #5 clk = ~clk;

  sm83_ir_queue_if #(.WORD_SIZE(8)) bus ();

  sm83_ir_queue #(.WORD_SIZE(8), .QUEUE_DEPTH(2)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  logic [8:0] exp_q[$];
  logic       pend_cb;

  // Reference opcode tables, written as explicit opcode lists.
  function automatic sm83_opc_class_t ref_class(input logic cb, input logic [7:0] b);
    if (cb) return CLS_CB;
    if (b == 8'h00) return CLS_NOP;
    if (b inside {8'h76, 8'h10, 8'hF3, 8'hFB, 8'hCB, 8'hD3, 8'hDB, 8'hDD,
                  8'hE3, 8'hE4, 8'hEB, 8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD}) return CLS_MISC;
    if ((b >= 8'h40 && b <= 8'h7F) ||
        b inside {8'h02, 8'h12, 8'h22, 8'h32, 8'h0A, 8'h1A, 8'h2A, 8'h3A,
                  8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
                  8'hE0, 8'hF0, 8'hE2, 8'hF2, 8'hEA, 8'hFA}) return CLS_LD8;
    if (b inside {8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hF8, 8'hF9,
                  8'hC1, 8'hD1, 8'hE1, 8'hF1, 8'hC5, 8'hD5, 8'hE5, 8'hF5}) return CLS_LD16;
    if (b inside {8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'hC0, 8'hC8, 8'hD0, 8'hD8,
                  8'hC9, 8'hD9, 8'hC2, 8'hCA, 8'hD2, 8'hDA, 8'hC3, 8'hC4, 8'hCC,
                  8'hD4, 8'hDC, 8'hCD, 8'hE9, 8'hC7, 8'hCF, 8'hD7, 8'hDF,
                  8'hE7, 8'hEF, 8'hF7, 8'hFF}) return CLS_JUMP;
    return CLS_ALU;
  endfunction

  function automatic logic [1:0] ref_imm(input logic cb, input logic [7:0] b);
    if (cb) return 2'd0;
    if (b inside {8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hCA, 8'hD2, 8'hDA,
                  8'hC3, 8'hC4, 8'hCC, 8'hD4, 8'hDC, 8'hCD, 8'hEA, 8'hFA}) return 2'd2;
    if (b inside {8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
                  8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
                  8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'h10, 8'hE0, 8'hF0,
                  8'hE8, 8'hF8}) return 2'd1;
    return 2'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.fetch_valid = 1'b0;
    bus.fetch_data  = 8'h00;
    bus.flush       = 1'b0;
    bus.issue_ready = 1'b0;
    bus.irq_pending = 1'b0;
    bus.ime         = 1'b0;
  endtask

  task automatic expect_issue(input string tag, input logic cb, input logic [7:0] b);
    check({tag, ".valid"}, 32'(bus.issue_valid), 32'd1);
    check({tag, ".ir"},    32'(bus.ir), 32'(b));
    check({tag, ".bank"},  32'(bus.bank_cb), 32'(cb));
    check({tag, ".class"}, 32'(bus.op_class), 32'(ref_class(cb, b)));
    check({tag, ".imm"},   32'(bus.imm_len), 32'(ref_imm(cb, b)));
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = b;
    tick();
    bus.fetch_valid = 1'b0;
  endtask

  task automatic handshake();
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
  endtask

  task automatic model_push(input logic [7:0] b);
    if (pend_cb) begin
      exp_q.push_back({1'b1, b});
      pend_cb = 1'b0;
    end else if (b == 8'hCB) begin
      pend_cb = 1'b1;
    end else begin
      exp_q.push_back({1'b0, b});
    end
  endtask

  initial begin
    logic       push_now;
    logic       hs_now;
    logic [7:0] rb;
    logic [8:0] e;
    int         sent;

    idle();
    #2 nreset = 1'b0;
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;

    // Reset state
    check("rst.valid",    32'(bus.issue_valid), 32'd0);
    check("rst.ir",       32'(bus.ir), 32'h00);
    check("rst.bank",     32'(bus.bank_cb), 32'd0);
    check("rst.class",    32'(bus.op_class), 32'(CLS_NOP));
    check("rst.imm",      32'(bus.imm_len), 32'd0);
    check("rst.halt",     32'(bus.in_halt), 32'd0);
    check("rst.haltbug",  32'(bus.halt_bug), 32'd0);
    check("rst.ready",    32'(bus.fetch_ready), 32'd1);

    // Test 1: LD A,n then NOP; one-cycle latency, full flag
    bus.fetch_valid = 1'b1; bus.fetch_data = 8'h3E; tick();
    check("t1.lat0", 32'(bus.issue_valid), 32'd0);
    bus.fetch_data = 8'h12; tick();
    expect_issue("t1.a", 1'b0, 8'h3E);
    check("t1.ready1", 32'(bus.fetch_ready), 32'd1);
    bus.fetch_data = 8'h00; tick();
    check("t1.full", 32'(bus.fetch_ready), 32'd0);
    expect_issue("t1.hold", 1'b0, 8'h3E);
    bus.fetch_valid = 1'b0;
    handshake();
    check("t1.gap", 32'(bus.issue_valid), 32'd0);
    tick();
    expect_issue("t1.b", 1'b0, 8'h12);
    check("t1.ready2", 32'(bus.fetch_ready), 32'd1);
    handshake(); tick();
    expect_issue("t1.c", 1'b0, 8'h00);
    handshake(); tick();
    check("t1.empty", 32'(bus.issue_valid), 32'd0);
    $display("t1 LD A,n / LD (DE),A / NOP sequence done");

    // Test 2: CB prefix folding
    bus.fetch_valid = 1'b1; bus.fetch_data = 8'hCB; tick();
    bus.fetch_data = 8'h7C; tick();
    check("t2.prefix_valid", 32'(bus.issue_valid), 32'd0);
    check("t2.prefix_bank",  32'(bus.bank_cb), 32'd1);
    bus.fetch_valid = 1'b0; tick();
    expect_issue("t2.a", 1'b1, 8'h7C);
    handshake(); tick();
    check("t2.single", 32'(bus.issue_valid), 32'd0);
    bus.fetch_valid = 1'b1; bus.fetch_data = 8'hCB; tick();
    tick();
    bus.fetch_valid = 1'b0; tick();
    expect_issue("t2.b", 1'b1, 8'hCB);
    handshake(); tick();
    check("t2.single2", 32'(bus.issue_valid), 32'd0);
    $display("t2 CB prefix pairs done");

    // Test 3: HALT without pending interrupt, woken by irq_pending
    push_byte(8'h76); tick();
    expect_issue("t3.halt", 1'b0, 8'h76);
    handshake();
    check("t3.in_halt", 32'(bus.in_halt), 32'd1);
    check("t3.novalid", 32'(bus.issue_valid), 32'd0);
    push_byte(8'h04);
    check("t3.still_halt", 32'(bus.in_halt), 32'd1);
    check("t3.still_novalid", 32'(bus.issue_valid), 32'd0);
    bus.irq_pending = 1'b1; tick();
    bus.irq_pending = 1'b0;
    check("t3.wake", 32'(bus.in_halt), 32'd0);
    tick();
    expect_issue("t3.resume", 1'b0, 8'h04);
    handshake();
    $display("t3 HALT / wake done");

    // Test 4: HALT bug, next byte issues twice
    bus.fetch_valid = 1'b1; bus.fetch_data = 8'h76; tick();
    bus.fetch_data = 8'h3C; tick();
    bus.fetch_valid = 1'b0;
    expect_issue("t4.halt", 1'b0, 8'h76);
    bus.irq_pending = 1'b1; bus.ime = 1'b0;
    handshake();
    bus.irq_pending = 1'b0;
    check("t4.bug",     32'(bus.halt_bug), 32'd1);
    check("t4.no_halt", 32'(bus.in_halt), 32'd0);
    tick();
    check("t4.bug_pulse", 32'(bus.halt_bug), 32'd0);
    expect_issue("t4.first", 1'b0, 8'h3C);
    handshake(); tick();
    expect_issue("t4.second", 1'b0, 8'h3C);
    handshake(); tick();
    check("t4.empty", 32'(bus.issue_valid), 32'd0);
    check("t4.ready", 32'(bus.fetch_ready), 32'd1);
    $display("t4 HALT bug replay done");

    // Test 5: flush with a full queue, with free space, in PREFIX and in HALT
    bus.fetch_valid = 1'b1; bus.fetch_data = 8'h00; tick();
    bus.fetch_data = 8'h01; tick();
    bus.fetch_data = 8'h34; tick();
    check("t5.full", 32'(bus.fetch_ready), 32'd0);
    bus.flush = 1'b1; bus.fetch_data = 8'hAA; tick();
    bus.flush = 1'b0; bus.fetch_valid = 1'b0;
    check("t5.valid", 32'(bus.issue_valid), 32'd0);
    check("t5.ready", 32'(bus.fetch_ready), 32'd1);
    check("t5.bank",  32'(bus.bank_cb), 32'd0);
    tick(); tick();
    check("t5.dropped", 32'(bus.issue_valid), 32'd0);
    bus.flush = 1'b1; bus.fetch_valid = 1'b1; bus.fetch_data = 8'hAA; tick();
    bus.flush = 1'b0; bus.fetch_valid = 1'b0;
    tick(); tick();
    check("t5.nopush", 32'(bus.issue_valid), 32'd0);
    push_byte(8'hCB); tick();
    check("t5.prefix", 32'(bus.bank_cb), 32'd1);
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    check("t5.prefix_clr", 32'(bus.bank_cb), 32'd0);
    push_byte(8'h00); tick();
    expect_issue("t5.after_prefix", 1'b0, 8'h00);
    handshake();
    push_byte(8'h76); tick();
    handshake();
    check("t5.halted", 32'(bus.in_halt), 32'd1);
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    check("t5.halt_clr", 32'(bus.in_halt), 32'd0);
    $display("t5 flush cases done");

    // Test 6: asynchronous reset while in PREFIX
    push_byte(8'h3E); tick();
    handshake();
    push_byte(8'hCB); tick();
    check("t6.prefix", 32'(bus.bank_cb), 32'd1);
    #1 nreset = 1'b0;
    #1;
    check("t6.valid", 32'(bus.issue_valid), 32'd0);
    check("t6.bank",  32'(bus.bank_cb), 32'd0);
    check("t6.ir",    32'(bus.ir), 32'h00);
    check("t6.class", 32'(bus.op_class), 32'(CLS_NOP));
    check("t6.imm",   32'(bus.imm_len), 32'd0);
    check("t6.ready", 32'(bus.fetch_ready), 32'd1);
    tick();
    nreset = 1'b1;
    tick();
    check("t6.idle", 32'(bus.issue_valid), 32'd0);
    push_byte(8'h00); tick();
    expect_issue("t6.after", 1'b0, 8'h00);
    handshake();
    $display("t6 async reset in PREFIX done");

    // Random stream with interrupts enabled: HALT never sticks
    bus.irq_pending = 1'b1;
    bus.ime = 1'b1;
    pend_cb = 1'b0;
    sent = 0;
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      if (sent >= 150 && !pend_cb && exp_q.size() == 0) break;
      rb = ($urandom_range(0, 3) == 0) ? 8'hCB : 8'($urandom_range(0, 255));
      bus.fetch_valid = (sent < 150 || pend_cb) && ($urandom_range(0, 3) != 0);
      bus.fetch_data  = rb;
      bus.issue_ready = ($urandom_range(0, 2) != 0);
      push_now = bus.fetch_valid && bus.fetch_ready;
      hs_now   = bus.issue_valid && bus.issue_ready;
      check("rnd.halt", 32'(bus.in_halt), 32'd0);
      check("rnd.haltbug", 32'(bus.halt_bug), 32'd0);
      if (hs_now) begin
        if (exp_q.size() == 0) begin
          check("rnd.spurious", 32'(bus.issue_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          expect_issue("rnd", e[8], e[7:0]);
          $display("rnd issue ir=%02h cb=%0d", e[7:0], e[8]);
        end
      end
      if (push_now) begin
        sent++;
        model_push(rb);
      end
      tick();
    end
    idle();
    check("rnd.drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
